program_mem_arbiter: RTL and testbench
======================================

// Module: program_mem_arbiter
// PURPOSE
//  Shares one program-memory read port between NUM_FETCHERS per-core fetch units.
//  Uses round-robin arbitration. One transaction is outstanding at a time.
//  Sits between the fetch units (valid/address held until ready) and the program memory controller.
//  Returns read data and a one-cycle ready pulse to the granted fetcher only.
// PARAMETERS
//  NUM_FETCHERS           4   number of requesting fetch units (>=1)
//  PROGRAM_MEM_ADDR_BITS  8   address width
//  PROGRAM_MEM_DATA_BITS  16  instruction width
// PORTS
//  clk                       in   1      clock, rising edge
//  reset                     in   1      async, active-high; clears all state
//  fetcher_read_valid        in   N      per-fetcher request, held until its ready
//  fetcher_read_address      in   N*A    packed addresses, slice i = fetcher i
//  fetcher_read_ready        out  N      one-cycle completion pulse, one-hot
//  fetcher_read_data         out  N*D    packed data; slice i valid while ready[i]=1
//  mem_read_valid            out  1      request to program memory
//  mem_read_address          out  A      address to program memory
//  mem_read_ready            in   1      memory completion, data valid same cycle
//  mem_read_data             in   D      instruction from memory
//  grant_id                  out  clog2N current/last granted fetcher (0 when N=1)
//  busy                      out  1      1 in any state except IDLE
// BEHAVIOUR
//  Reset (async, immediate)
//   - State -> IDLE.
//   - All outputs 0. RR pointer 0. Data slices 0.
//  FSM states and transitions
//   - IDLE: if any valid, pick the first set bit at or after ptr, wrapping mod N.
//     Latch grant_id and that fetcher's address. Set mem_read_valid=1. -> ISSUE.
//   - ISSUE: hold mem_read_valid and address stable. On mem_read_ready:
//     capture mem_read_data into slice grant_id, mem_read_valid<=0, -> RESPOND.
//   - RESPOND: fetcher_read_ready[grant_id]=1 for exactly this cycle.
//     ptr <= (grant_id+1) mod N. -> COOLDOWN.
//   - COOLDOWN: one cycle, no arbitration. Lets the served fetcher drop its valid. -> IDLE.
//  Latency and throughput
//   - Valid seen in IDLE cycle t: mem_read_valid=1 at t+1.
//   - mem_read_ready in cycle k: ready pulse at k+1, next grant possible at k+3.
//   - With zero-wait memory (ready in the first ISSUE cycle), minimum is 4 cycles per fetch.
//  Handshakes and fairness
//   - All outputs are registered. No combinational path from any input to any output.
//   - mem_read_ready outside ISSUE is ignored.
//   - Request address is sampled only at grant. Later changes are ignored.
//   - A fetcher that deasserts valid after grant still gets its transaction completed and pulsed.
//   - Non-granted fetchers see ready=0 and their data slices unchanged.
//   - Simultaneous requests: RR order from ptr. Any requester waits at most N-1 grants.
//  Width and boundary rules
//   - ptr and grant_id wrap N-1 -> 0.
//   - N=1: grant_id is always 0; behaviour is otherwise identical.
//   - Reset mid-ISSUE: mem_read_valid drops immediately. No ready pulse is ever produced
//     for the aborted request.
// TESTING
//  1. Reset: any stimulus -> all outputs 0, busy=0. Then N=4, valid=4'b0001, addr0=8'h10,
//     mem ready 1 cycle after valid -> mem addr 8'h10, ready[0] pulse one cycle, data slice0=mem data.
//  2. Contention: valid=4'b1111, addrs 8'h00/11/22/33, zero-wait mem -> grants 0,1,2,3,0.
//     Each grant exactly 4 cycles apart.
//  3. Fairness: valid=4'b1001 after a grant to 3 -> next grant 0, then 3.
//     No starvation over 100 transactions.
//  4. Wait states: mem_read_ready delayed 5 cycles -> mem_read_valid/address stable all 5 cycles.
//     Exactly one ready pulse. Stray mem_read_ready in IDLE produces no output.
//  5. Reset in ISSUE: assert reset while busy=1 -> mem_read_valid=0 in the same cycle.
//     After release, ptr=0 and no ready pulse appears.
//  6. Requester drops valid after grant (addr 8'hA5) -> transaction completes at 8'hA5.
//     ready pulse still issued. Address change after grant not propagated.

Source files
------------

// File: rtl/program_mem_arbiter.sv
// Round-robin arbiter sharing one program-memory read port between NUM_FETCHERS fetch units.
// Latency: valid seen in IDLE -> mem_read_valid next cycle; mem_read_ready at k -> ready pulse k+1, re-arbitrate k+3.
// Backpressure: one transaction in flight; requesters hold valid/address until their one-cycle ready pulse.
module program_mem_arbiter #(
  parameter int NUM_FETCHERS          = 4,
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  localparam int GW = (NUM_FETCHERS > 1) ? $clog2(NUM_FETCHERS) : 1
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic [NUM_FETCHERS-1:0]                         fetcher_read_valid,
  input  logic [NUM_FETCHERS*PROGRAM_MEM_ADDR_BITS-1:0]   fetcher_read_address,
  output logic [NUM_FETCHERS-1:0]                         fetcher_read_ready,
  output logic [NUM_FETCHERS*PROGRAM_MEM_DATA_BITS-1:0]   fetcher_read_data,
  output logic                                            mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0]                mem_read_address,
  input  logic                                            mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0]                mem_read_data,
  output logic [GW-1:0]                                   grant_id,
  output logic                                            busy
);

  localparam int N = NUM_FETCHERS;
  localparam int A = PROGRAM_MEM_ADDR_BITS;
  localparam int D = PROGRAM_MEM_DATA_BITS;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESPOND, S_COOLDOWN} state_t;

  state_t         state_q, state_d;
  logic [GW-1:0]  ptr_q, ptr_d;
  logic [GW-1:0]  grant_q, grant_d;
  logic [A-1:0]   addr_q, addr_d;
  logic           mvld_q, mvld_d;
  logic [N-1:0]   rdy_q, rdy_d;
  logic [N*D-1:0] data_q, data_d;
  logic           busy_q, busy_d;

  logic           pick_vld;
  logic [GW-1:0]  pick_idx;
  logic [GW-1:0]  cand;

  // Round-robin pick: descending scan so the requester closest to ptr (at or after it) wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = GW'((int'(ptr_q) + k) % N);
      if (fetcher_read_valid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Next-state and registered-output computation; ready pulse defaults low every cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    mvld_d  = mvld_q;
    rdy_d   = '0;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          addr_d  = fetcher_read_address[int'(pick_idx)*A +: A];
          mvld_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_read_ready) begin
          data_d[int'(grant_q)*D +: D] = mem_read_data;
          mvld_d         = 1'b0;
          rdy_d[grant_q] = 1'b1;
          state_d        = S_RESPOND;
        end
      end
      S_RESPOND: begin
        // Pointer advances only once the transaction is delivered, so an aborted one never moves it.
        ptr_d   = (int'(grant_q) == N - 1) ? '0 : grant_q + GW'(1);
        state_d = S_COOLDOWN;
      end
      default: begin
        // Cooldown gives the served fetcher a cycle to drop valid before re-arbitration.
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; async reset aborts any in-flight request immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      mvld_q  <= 1'b0;
      rdy_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      mvld_q  <= mvld_d;
      rdy_q   <= rdy_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  assign fetcher_read_ready = rdy_q;
  assign fetcher_read_data  = data_q;
  assign mem_read_valid     = mvld_q;
  assign mem_read_address   = addr_q;
  assign grant_id           = grant_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_program_mem_arbiter.sv
// Self-checking bench for program_mem_arbiter: directed scenarios plus a randomized run against a cycle-level model.
// Inputs are driven and outputs sampled on the falling edge of clk.
// Memory responses are generated by the bench with optional wait states and stray ready pulses.
module tb_program_mem_arbiter;
  localparam int N = 4;
  localparam int A = 8;
  localparam int D = 16;

  typedef int arr8_t [8];

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   fvalid;
  logic [N*A-1:0] faddr;
  logic [N-1:0]   frdy;
  logic [N*D-1:0] fdata;
  logic           mvalid;
  logic [A-1:0]   maddr;
  logic           mrdy;
  logic [D-1:0]   mdata;
  logic [1:0]     gid;
  logic           busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  program_mem_arbiter #(
    .NUM_FETCHERS(N), .PROGRAM_MEM_ADDR_BITS(A), .PROGRAM_MEM_DATA_BITS(D)
  ) dut (
    .clk(clk), .reset(reset),
    .fetcher_read_valid(fvalid), .fetcher_read_address(faddr),
    .fetcher_read_ready(frdy), .fetcher_read_data(fdata),
    .mem_read_valid(mvalid), .mem_read_address(maddr),
    .mem_read_ready(mrdy), .mem_read_data(mdata),
    .grant_id(gid), .busy(busy)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; fvalid = '0; faddr = '0; mrdy = 1'b0; mdata = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  function automatic logic [D-1:0] dslice(logic [N*D-1:0] v, int i);
    return v[i*D +: D];
  endfunction

  // Reference round-robin choice: first requester at or after p, wrapping.
  function automatic int rr(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Zero-wait memory; records each new grant (rising mem_read_valid) until 'want' are seen.
  task automatic run_grants(input int want, output int ng, output arr8_t ids,
                            output arr8_t adr, output arr8_t cyc);
    logic prev;
    int   c;
    prev = mvalid; ng = 0; c = 0;
    for (int i = 0; i < 8; i++) begin ids[i] = -1; adr[i] = -1; cyc[i] = -1; end
    while (ng < want && c < 80) begin
      tick(); c++;
      if (mvalid && !prev) begin
        ids[ng] = int'(gid); adr[ng] = int'(maddr); cyc[ng] = c; ng++;
      end
      prev  = mvalid;
      mrdy  = mvalid;
      mdata = D'($urandom);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fvalid = N'($urandom); faddr = (N*A)'($urandom); mrdy = 1'($urandom); mdata = D'($urandom);
      tick();
      tests++;
      if ({frdy, fdata, mvalid, maddr, gid, busy} !== '0) begin
        fails++; $display("FAIL reset_outputs got rdy=%b data=%h mv=%b ma=%h gid=%0d busy=%b want all 0",
                          frdy, fdata, mvalid, maddr, gid, busy);
      end
    end
    reset = 1'b0; fvalid = 4'b0001; faddr = '0; faddr[0 +: A] = 8'h10; mrdy = 1'b0;
    tick();
    tests++;
    if (mvalid !== 1'b1 || maddr !== 8'h10) begin
      fails++; $display("FAIL first_issue got mv=%b addr=%h want 1/10", mvalid, maddr);
    end
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL first_busy got %b want 1", busy); end
    mrdy = 1'b1; mdata = 16'hBEEF;
    tick();
    tests++;
    if (frdy !== 4'b0001 || dslice(fdata, 0) !== 16'hBEEF) begin
      fails++; $display("FAIL first_respond got rdy=%b d0=%h want 0001/beef", frdy, dslice(fdata, 0));
    end
    tests++;
    if (mvalid !== 1'b0) begin fails++; $display("FAIL first_mvalid_drop got %b want 0", mvalid); end
    fvalid = '0; mrdy = 1'b0;
    tick();
    tests++;
    if (frdy !== 4'b0000) begin fails++; $display("FAIL first_pulse_width got %b want 0000", frdy); end
    tick();
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL first_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_contention();
    int ng; arr8_t ids, adr, cyc;
    do_reset();
    fvalid = 4'b1111; faddr = {8'h33, 8'h22, 8'h11, 8'h00};
    run_grants(5, ng, ids, adr, cyc);
    tests++;
    if (ng !== 5) begin fails++; $display("FAIL cont_count got %0d grants want 5", ng); end
    for (int k = 0; k < 5; k++) begin
      tests++;
      if (ids[k] !== k % 4 || adr[k] !== (k % 4) * 'h11) begin
        fails++; $display("FAIL cont_grant%0d got id=%0d addr=%h want id=%0d addr=%h",
                          k, ids[k], adr[k], k % 4, (k % 4) * 'h11);
      end
      if (k > 0) begin
        tests++;
        if (cyc[k] - cyc[k-1] !== 4) begin
          fails++; $display("FAIL cont_spacing%0d got %0d cycles want 4", k, cyc[k] - cyc[k-1]);
        end
      end
    end
  endtask

  task automatic test_fairness();
    int ng; arr8_t ids, adr, cyc;
    do_reset();
    fvalid = 4'b1000; faddr = {8'h3C, 8'h2C, 8'h1C, 8'h0C};
    run_grants(1, ng, ids, adr, cyc);
    tests++;
    if (ng !== 1 || ids[0] !== 3) begin fails++; $display("FAIL fair_first got id=%0d want 3", ids[0]); end
    fvalid = 4'b1001;
    run_grants(2, ng, ids, adr, cyc);
    tests++;
    if (ng !== 2 || ids[0] !== 0 || ids[1] !== 3) begin
      fails++; $display("FAIL fair_order got %0d,%0d want 0,3", ids[0], ids[1]);
    end
  endtask

  task automatic test_wait_states();
    int pulses;
    do_reset();
    fvalid = 4'b0010; faddr[1*A +: A] = 8'h5C;
    tick();
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (mvalid !== 1'b1 || maddr !== 8'h5C) begin
        fails++; $display("FAIL wait_stable%0d got mv=%b addr=%h want 1/5c", i, mvalid, maddr);
      end
      tick();
    end
    mrdy = 1'b1; mdata = 16'h1357; pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      mrdy = 1'b0;
      if (frdy !== '0) begin
        pulses++;
        tests++;
        if (frdy !== 4'b0010 || dslice(fdata, 1) !== 16'h1357) begin
          fails++; $display("FAIL wait_pulse got rdy=%b d1=%h want 0010/1357", frdy, dslice(fdata, 1));
        end
      end
      fvalid = fvalid & ~frdy;
    end
    tests++;
    if (pulses !== 1) begin fails++; $display("FAIL wait_pulse_count got %0d want 1", pulses); end
    fvalid = '0;
    for (int i = 0; i < 3; i++) begin
      mrdy = 1'b1; mdata = D'($urandom);
      tick();
      tests++;
      if (frdy !== '0 || mvalid !== 1'b0 || busy !== 1'b0 || dslice(fdata, 1) !== 16'h1357) begin
        fails++; $display("FAIL stray_ready got rdy=%b mv=%b busy=%b d1=%h want 0/0/0/1357",
                          frdy, mvalid, busy, dslice(fdata, 1));
      end
    end
    mrdy = 1'b0;
  endtask

  task automatic test_reset_issue();
    int pulses;
    do_reset();
    fvalid = 4'b0010; faddr[1*A +: A] = 8'h11;
    tick();
    mrdy = 1'b1; mdata = 16'h0001;
    tick();
    mrdy = 1'b0; fvalid = 4'b0100; faddr[2*A +: A] = 8'h22;
    tick(); tick(); tick();
    tests++;
    if (busy !== 1'b1 || mvalid !== 1'b1 || gid !== 2'd2) begin
      fails++; $display("FAIL rst_pre got busy=%b mv=%b gid=%0d want 1/1/2", busy, mvalid, gid);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (mvalid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL rst_immediate got mv=%b busy=%b want 0/0", mvalid, busy);
    end
    tick();
    reset = 1'b0; fvalid = '0; pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (frdy !== '0) pulses++;
    end
    tests++;
    if (pulses !== 0) begin fails++; $display("FAIL rst_no_pulse got %0d pulses want 0", pulses); end
    fvalid = 4'b1111;
    tick();
    tests++;
    if (gid !== 2'd0 || mvalid !== 1'b1) begin
      fails++; $display("FAIL rst_ptr got gid=%0d mv=%b want 0/1", gid, mvalid);
    end
  endtask

  task automatic test_drop_valid();
    do_reset();
    fvalid = 4'b0001; faddr[0 +: A] = 8'hA5;
    tick();
    fvalid = '0; faddr[0 +: A] = 8'hFF;
    tick(); tick();
    tests++;
    if (mvalid !== 1'b1 || maddr !== 8'hA5) begin
      fails++; $display("FAIL drop_addr got mv=%b addr=%h want 1/a5", mvalid, maddr);
    end
    mrdy = 1'b1; mdata = 16'h4242;
    tick();
    mrdy = 1'b0;
    tests++;
    if (frdy !== 4'b0001 || dslice(fdata, 0) !== 16'h4242) begin
      fails++; $display("FAIL drop_pulse got rdy=%b d0=%h want 0001/4242", frdy, dslice(fdata, 0));
    end
    tick(); tick(); tick();
    tests++;
    if (busy !== 1'b0 || mvalid !== 1'b0) begin
      fails++; $display("FAIL drop_regrant got busy=%b mv=%b want 0/0", busy, mvalid);
    end
  endtask

  task automatic test_random();
    logic [N-1:0]   v, er;
    logic [A-1:0]   a [N];
    logic [D-1:0]   ed [N];
    logic [N*D-1:0] edv;
    logic [A-1:0]   eaddr;
    int waits [N];
    int cur, done, k_done, next_arb, ptr, egid, ngr, x, g;
    logic exp_mv, exp_busy;
    do_reset();
    v = '0; eaddr = '0;
    for (int i = 0; i < N; i++) begin a[i] = '0; ed[i] = '0; waits[i] = 0; end
    cur = -1; done = 0; k_done = -100; next_arb = 0; ptr = 0; egid = 0; ngr = 0; x = 0;
    while (ngr < 120 && x < 4000) begin
      exp_mv   = (cur >= 0);
      exp_busy = (cur >= 0) || (x < next_arb);
      er = '0;
      if (x == k_done + 1) er[done] = 1'b1;
      for (int i = 0; i < N; i++) edv[i*D +: D] = ed[i];
      tests++;
      if (mvalid !== exp_mv || (exp_mv && maddr !== eaddr)) begin
        fails++; $display("FAIL rnd_mem cyc=%0d got mv=%b addr=%h want %b/%h", x, mvalid, maddr, exp_mv, eaddr);
      end
      tests++;
      if (frdy !== er || fdata !== edv) begin
        fails++; $display("FAIL rnd_resp cyc=%0d got rdy=%b data=%h want %b/%h", x, frdy, fdata, er, edv);
      end
      tests++;
      if (busy !== exp_busy || int'(gid) !== egid) begin
        fails++; $display("FAIL rnd_status cyc=%0d got busy=%b gid=%0d want %b/%0d", x, busy, gid, exp_busy, egid);
      end
      for (int i = 0; i < N; i++) begin
        if (er[i]) v[i] = 1'b0;
        else if (!v[i] && $urandom_range(0, 3) == 0) begin v[i] = 1'b1; a[i] = A'($urandom); end
        else if (v[i] && i == cur && $urandom_range(0, 3) == 0) a[i] = A'($urandom);
        faddr[i*A +: A] = a[i];
      end
      fvalid = v;
      mrdy   = (cur >= 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      mdata  = D'($urandom);
      if (cur >= 0) begin
        if (mrdy) begin
          ed[cur] = mdata; done = cur; k_done = x; ptr = (cur + 1) % N;
          next_arb = x + 3; cur = -1; ngr++;
        end
      end else if (x >= next_arb && v != '0) begin
        g = rr(v, ptr);
        for (int i = 0; i < N; i++) begin
          if (i != g && v[i]) begin
            waits[i]++;
            tests++;
            if (waits[i] > N - 1) begin
              fails++; $display("FAIL rnd_starve fetcher=%0d got %0d grants waited want <=%0d", i, waits[i], N - 1);
            end
          end
        end
        waits[g] = 0; cur = g; egid = g; eaddr = a[g];
      end
      tick();
      x++;
    end
    tests++;
    if (ngr < 120) begin fails++; $display("FAIL rnd_timeout got %0d transactions want 120", ngr); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; fvalid = '0; faddr = '0; mrdy = 1'b0; mdata = '0;
    tick();
    test_reset();
    test_contention();
    test_fairness();
    test_wait_states();
    test_reset_issue();
    test_drop_valid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
